// File: rtl/waveform_pkg.sv
// Shared types and default widths for the waveform player and its BRAM-side neighbours.
package waveform_pkg;

  localparam int WORD_WID = 20;
  localparam int DAC_WID  = 24;

  localparam logic [3:0] DAC_WRITE_CMD = 4'b0001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_OK,
    ST_ARM,
    ST_WAIT_DAC,
    ST_WAIT_TIMER,
    ST_ADVANCE,
    ST_DONE
  } wp_state_t;

endpackage

// File: rtl/waveform_timer.sv
// Saturating sample-interval counter with synchronous clear and a >= limit compare.
module waveform_timer #(
  parameter int TIMER_WID = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [TIMER_WID-1:0] limit,
  output logic                 expired
);

  logic [TIMER_WID-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (clr)         cnt <= '0;
    else if (cnt != '1)   cnt <= cnt + 1'b1;
  end

  assign expired = (cnt >= limit);

endmodule

// File: rtl/waveform_player.sv
// Streams BRAM words to the DAC at a programmable interval, one-shot or looping.
// Optional sample counter output enabled by defining WAVEFORM_PLAYER_SAMPLE_CNT_EN.
module waveform_player #(
  parameter int WORD_WID  = 20,
  parameter int TIMER_WID = 32,
  parameter int DAC_WID   = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 do_loop,
  input  logic [TIMER_WID-1:0] time_to_wait,
  output logic                 finished,
  output logic                 running,
  input  logic [WORD_WID-1:0]  word,
  input  logic                 word_ok,
  input  logic                 word_last,
  output logic                 word_next,
  output logic                 word_rst,
  output logic [DAC_WID-1:0]   dac_out,
  output logic                 dac_arm,
  input  logic                 dac_finished
`ifdef WAVEFORM_PLAYER_SAMPLE_CNT_EN
  ,
  output logic [31:0]          sample_cnt
`endif
);
  import waveform_pkg::*;

  wp_state_t            state;
  logic                 loop_q;
  logic                 last_q;
  logic [TIMER_WID-1:0] wait_q;
  logic                 tmr_clr;
  logic                 tmr_done;
  logic                 pulsed;

  // Timer is held clear until the ARM cycle so it measures from the launch.
  assign tmr_clr = (state == ST_IDLE) || (state == ST_WAIT_OK);
  // word_ok is stale in the cycle the upstream is still reacting to our pulse.
  assign pulsed  = word_next | word_rst;

  waveform_timer #(.TIMER_WID(TIMER_WID)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .limit   (wait_q),
    .expired (tmr_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      loop_q    <= 1'b0;
      last_q    <= 1'b0;
      wait_q    <= '0;
      finished  <= 1'b0;
      running   <= 1'b0;
      word_next <= 1'b0;
      word_rst  <= 1'b0;
      dac_out   <= '0;
      dac_arm   <= 1'b0;
    end else begin
      word_next <= 1'b0;
      word_rst  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run) begin
            loop_q   <= do_loop;
            wait_q   <= time_to_wait;
            word_rst <= 1'b1;
            running  <= 1'b1;
            state    <= ST_WAIT_OK;
          end
        end
        ST_WAIT_OK: begin
          if (!run) begin
            word_rst <= 1'b1;
            running  <= 1'b0;
            state    <= ST_IDLE;
          end else if (!pulsed && word_ok) begin
            dac_out <= DAC_WID'({DAC_WRITE_CMD, word});
            last_q  <= word_last;
            state   <= ST_ARM;
          end
        end
        ST_ARM: begin
          dac_arm <= 1'b1;
          state   <= ST_WAIT_DAC;
        end
        ST_WAIT_DAC: begin
          // A launched transfer always runs to completion, run is not looked at here.
          if (dac_finished) begin
            dac_arm <= 1'b0;
            state   <= ST_WAIT_TIMER;
          end
        end
        ST_WAIT_TIMER: begin
          if (!run) begin
            word_rst <= 1'b1;
            running  <= 1'b0;
            state    <= ST_IDLE;
          end else if (tmr_done) begin
            state <= ST_ADVANCE;
          end
        end
        ST_ADVANCE: begin
          if (!run) begin
            word_rst <= 1'b1;
            running  <= 1'b0;
            state    <= ST_IDLE;
          end else if (!last_q) begin
            word_next <= 1'b1;
            state     <= ST_WAIT_OK;
          end else if (loop_q) begin
            word_rst <= 1'b1;
            state    <= ST_WAIT_OK;
          end else begin
            finished <= 1'b1;
            running  <= 1'b0;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!run) begin
            finished <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          running <= 1'b0;
          dac_arm <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef WAVEFORM_PLAYER_SAMPLE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   sample_cnt <= '0;
    else if (state == ST_IDLE && run)          sample_cnt <= '0;
    else if (state == ST_WAIT_DAC && dac_finished && sample_cnt != '1)
                                               sample_cnt <= sample_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_waveform_player.sv
// Bench for waveform_player: scenario table plus hand-written stop and stall/reset sequences.
module tb_waveform_player;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        do_loop = 1'b0;
  logic [31:0] time_to_wait = '0;
  logic        finished, running, word_next, word_rst, dac_arm, dac_finished;
  logic [19:0] word;
  logic        word_ok, word_last;
  logic [23:0] dac_out;
`ifdef WAVEFORM_PLAYER_SAMPLE_CNT_EN
  logic [31:0] sample_cnt;
`endif

  waveform_player dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .do_loop      (do_loop),
    .time_to_wait (time_to_wait),
    .finished     (finished),
    .running      (running),
    .word         (word),
    .word_ok      (word_ok),
    .word_last    (word_last),
    .word_next    (word_next),
    .word_rst     (word_rst),
    .dac_out      (dac_out),
    .dac_arm      (dac_arm),
    .dac_finished (dac_finished)
`ifdef WAVEFORM_PLAYER_SAMPLE_CNT_EN
    ,
    .sample_cnt   (sample_cnt)
`endif
  );

  always #5 clk = ~clk;

  // 4-word buffer 1..4; word_ok held off only while stall is set.
  int   idx = 0;
  logic stall = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst)                         idx <= 0;
    else if (word_rst)               idx <= 0;
    else if (word_next && idx < 3)   idx <= idx + 1;
  end
  assign word      = 20'(idx + 1);
  assign word_ok   = !stall;
  assign word_last = (idx == 3);

  // DAC model: dac_lat counts from the launch cycle to the cycle the player leaves WAIT_DAC,
  // so finished is visible dac_lat-2 cycles after arm rises.
  int dac_lat = 10;
  int dcnt = 0;
  always @(posedge clk or posedge rst) begin
    if (rst || !dac_arm) begin
      dcnt         <= 0;
      dac_finished <= 1'b0;
    end else begin
      dcnt         <= dcnt + 1;
      dac_finished <= (dcnt == dac_lat - 3);
    end
  end

  int passed = 0, total = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // Scoreboard and protocol monitor, sampled on the falling edge.
  logic [23:0] exp_q[$];
  int   cyc = 0, arms_seen = 0, last_rise = -1, exp_period = 0;
  int   nnext = 0, nrst = 0, both_err = 0, arm_err = 0, fin_seen = 0;
  logic arm_prev = 1'b0, fin_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [23:0] e;
    if (finished) fin_seen++;
    if (word_next) nnext++;
    if (word_rst) nrst++;
    if (word_next && word_rst) both_err++;
    if (dac_arm && !arm_prev) begin
      arms_seen++;
      check("arm_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("dac_out", dac_out, e);
      end
      if (exp_period != 0 && last_rise >= 0) check("period", cyc - last_rise, exp_period);
      last_rise = cyc;
    end
    if (arm_prev && !dac_arm && !rst && !fin_prev) arm_err++;
    arm_prev = dac_arm;
    fin_prev = dac_finished;
  end

  typedef struct {
    int tw;
    int lat;
    bit loop;
    int nsamp;
    int period;
    bit fin;
    int nnext;
    int nrst;
  } scen_t;

  task automatic run_scen(input scen_t sc);
    int b_next, b_rst, b_fin, b_arm, b_err, n, lim;
    dac_lat    = sc.lat;
    exp_period = sc.period;
    last_rise  = -1;
    for (int i = 0; i < sc.nsamp; i++) exp_q.push_back({4'h1, 20'(i % 4 + 1)});
    b_next = nnext; b_rst = nrst; b_fin = fin_seen; b_arm = arms_seen; b_err = arm_err;
    lim = sc.nsamp * (sc.period + 10) + 100;
    do_loop      = sc.loop;
    time_to_wait = 32'(sc.tw);
    run          = 1'b1;
    @(negedge clk);
    check("start_word_rst", word_rst, 1);
    check("start_running", running, 1);
`ifdef WAVEFORM_PLAYER_SAMPLE_CNT_EN
    check("sample_cnt_cleared", sample_cnt, 0);
`endif
    // Settings are latched at start; changes now must have no effect.
    do_loop      = !sc.loop;
    time_to_wait = 32'd3;
    n = 0;
    while (arms_seen - b_arm < sc.nsamp && n < lim) begin @(negedge clk); n++; end
    check("arms_reached", arms_seen - b_arm, sc.nsamp);
    if (sc.fin) begin
      n = 0;
      while (!finished && n < 300) begin @(negedge clk); n++; end
      check("finished", finished, 1);
      check("done_running", running, 0);
`ifdef WAVEFORM_PLAYER_SAMPLE_CNT_EN
      check("sample_cnt", sample_cnt, sc.nsamp);
`endif
    end
    run = 1'b0;
    n = 0;
    while ((running || finished) && n < 300) begin @(negedge clk); n++; end
    check("stopped", {running, finished}, 0);
    repeat (100) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("word_next_cnt", nnext - b_next, sc.nnext);
    check("word_rst_cnt", nrst - b_rst, sc.nrst);
    check("finished_seen", 64'((fin_seen - b_fin) > 0), 64'(sc.fin));
    check("arm_held_to_finish", arm_err - b_err, 0);
  endtask

  initial begin
    scen_t tbl[5];
    int n, b_arm, b_rst;
    tbl[0] = '{50, 10, 1'b0,  4, 54, 1'b1, 3, 1};  // one-shot
    tbl[1] = '{50, 10, 1'b1, 10, 54, 1'b0, 7, 4};  // loop, stopped after 10 samples
    tbl[2] = '{ 0, 20, 1'b0,  4, 24, 1'b1, 3, 1};  // interval shorter than transfer
    tbl[3] = '{11, 10, 1'b0,  4, 15, 1'b1, 3, 1};  // interval one past transfer
    tbl[4] = '{10, 10, 1'b1,  6, 14, 1'b0, 4, 3};  // interval equal to transfer

    repeat (3) @(negedge clk);
    check("rst_finished", finished, 0);
    check("rst_running", running, 0);
    check("rst_word_next", word_next, 0);
    check("rst_word_rst", word_rst, 0);
    check("rst_dac_arm", dac_arm, 0);
    check("rst_dac_out", dac_out, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int s = 0; s < 5; s++) run_scen(tbl[s]);

    // Stop while a transfer is in flight.
    dac_lat = 10; exp_period = 0; last_rise = -1;
    exp_q.push_back(24'h100001);
    b_arm = arms_seen; b_rst = nrst;
    do_loop = 1'b0; time_to_wait = 32'd50; run = 1'b1;
    n = 0;
    while (!dac_arm && n < 50) begin @(negedge clk); n++; end
    check("stop_arm_rise", dac_arm, 1);
    repeat (3) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    check("stop_arm_held", dac_arm, 1);
    n = 0;
    while (dac_arm && n < 50) begin @(negedge clk); n++; end
    check("stop_arm_drop", dac_arm, 0);
    n = 0;
    while (!word_rst && n < 5) begin @(negedge clk); n++; end
    check("stop_word_rst", word_rst, 1);
    @(negedge clk);
    check("stop_running", running, 0);
    repeat (100) @(negedge clk);
    check("stop_single_arm", arms_seen - b_arm, 1);
    check("stop_word_rst_cnt", nrst - b_rst, 2);
    check("stop_arm_err", arm_err, 0);

    // Upstream stall after a word_next, then async reset mid-transfer.
    dac_lat = 20; exp_period = 0; last_rise = -1;
    exp_q.push_back(24'h100001);
    exp_q.push_back(24'h100002);
    b_arm = arms_seen;
    time_to_wait = 32'd0; run = 1'b1;
    n = 0;
    while (arms_seen == b_arm && n < 50) begin @(negedge clk); n++; end
    stall = 1'b1;
    n = 0;
    while (!word_next && n < 100) begin @(negedge clk); n++; end
    check("stall_word_next", word_next, 1);
    repeat (100) @(negedge clk);
    check("stall_no_arm", arms_seen - b_arm, 1);
    check("stall_running", running, 1);
    stall = 1'b0;
    n = 0;
    while (arms_seen - b_arm < 2 && n < 20) begin @(negedge clk); n++; end
    check("stall_resume_arm", arms_seen - b_arm, 2);
    repeat (3) @(negedge clk);
    check("pre_rst_arm", dac_arm, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_dac_arm", dac_arm, 0);
    check("async_rst_dac_out", dac_out, 0);
    check("async_rst_running", running, 0);
    check("async_rst_pulses", {word_next, word_rst}, 0);
    check("async_rst_finished", finished, 0);
    run = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("final_queue", exp_q.size(), 0);
    check("no_next_rst_overlap", both_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
